spi_master_slave: RTL and testbench
===================================

Name: spi_master_slave

Overview:
- Self-contained SPI mode-0 (CPOL=0, CPHA=0) link: one master engine and one slave engine, wired together internally.
- Both engines run on the single system clock; the SPI wires (sclk, ss, mosi, miso) are also driven out as observation outputs.
- Performs a full-duplex 8-bit exchange, MSB first: the master's byte goes to the slave and the slave's byte goes to the master.
- Used as a loopback/bring-up block for SPI bus integration.

Parameters:
CLK_DIV, 1, sclk half-period in clk cycles; legal range 1..255. One sclk period = 2*CLK_DIV clk cycles.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset
start  input  1  transaction request; rising edge accepted only in IDLE
data_in_master  input  8  byte shifted out on mosi; captured when the transaction starts
data_in_slave  input  8  byte shifted out on miso; loaded continuously while ss=1
data_out_master  output  8  byte the master received
data_out_slave  output  8  byte the slave received
done  output  1  sticky transaction-complete flag
sclk  output  1  SPI clock, idles low
ss  output  1  slave select, active low
mosi  output  1  master-out data
miso  output  1  slave-out data

Behaviour:
- Reset (reset=0, asynchronous): master returns to IDLE; sclk=0, ss=1, mosi=0, done=0, data_out_master=0, data_out_slave=0; both bit counters=0; slave shift register=0.
- Start detection: start is registered; start_rise = start & ~start_q. A launch occurs only on start_rise while in IDLE. Holding start high does not relaunch. start_rise while busy is ignored.
- Master states: IDLE -> XFER -> IDLE.
- Launch edge k (CLK_DIV=1):
  - master shift register <= data_in_master;
  - ss <= 0; mosi = MSB; done <= 0; bit count <= 0.
- Each bit (CLK_DIV=1):
  - edge k+2i+1: sclk rises; master samples miso into its shift register LSB.
  - edge k+2i+2: sclk falls; master shifts so that mosi presents the next bit.
  - General CLK_DIV: each sclk phase lasts CLK_DIV clk cycles.
- After the 8th falling edge (edge k+16 at CLK_DIV=1):
  - ss <= 1, sclk stays 0, data_out_master <= received byte, done <= 1; return to IDLE.
  - Total latency = 16*CLK_DIV cycles from the launch edge.
- done stays high until the next accepted launch or reset.
- Slave engine:
  - While ss=1: shift register <= data_in_slave each cycle; bit count = 0.
  - miso = slave shift register[7] (combinational); 0 is not forced when ss=1.
  - Slave keeps a registered copy sclk_q of sclk. Detected rise = sclk & ~sclk_q, while ss=0.
  - On each detected rise: shift register <= {shreg[6:0], mosi}; bit count++.
  - Because detection lags sclk by one cycle, the slave captures mosi before the master's falling-edge update, and the next miso bit is valid before the next sclk rise.
  - On the 8th detected rise: data_out_slave <= the shifted value including that bit; bit count <= 0.
  - If ss rises early, bits received so far are discarded and data_out_slave is unchanged.
- Data-output update rule: data_out_master and data_out_slave change only at transaction completion.
- Reset mid-transaction: immediate abort to the reset values; no partial data is written.
- Back-to-back: a new start_rise in the cycle after done is accepted.

Optional Feature:
SPI_LSB_FIRST_EN
- Defined: both engines shift LSB first. Master mosi starts with bit0 and received bits enter at the MSB, shifting right. Slave miso = shreg[0] and receives at bit7.
- Undefined: MSB-first, as specified above.
- Timing and latency are identical in both cases.

Test Plan:
1. Reset, then start=1 held 16 cycles with data_in_master=8'hAA, data_in_slave=8'hCC. Required: done=1 within 18 cycles of start rising; data_out_master=8'hCC; data_out_slave=8'hAA; ss=1 and sclk=0 afterwards.
2. Check the waveform during case 1. Required: exactly 8 sclk pulses, each 1 cycle high and 1 cycle low; mosi sequence 1,0,1,0,1,0,1,0; miso sequence 1,1,0,0,1,1,0,0; ss low for exactly 16 cycles.
3. Keep start high after done. Required: no second transaction and done stays 1. Then drop start and raise it again with 8'h5A/8'h3C. Required: done falls at launch and rises 16 cycles later; outputs 8'h3C/8'h5A.
4. Assert reset=0 at bit 4 of a transaction. Required: ss=1, sclk=0, done=0, both data_out=0 immediately. A following full transaction with 8'hFF/8'h00 completes correctly.
5. CLK_DIV=4 with 8'h81/8'h7E. Required: sclk half-period of 4 cycles; done 64 cycles after launch; data_out_master=8'h7E, data_out_slave=8'h81.
6. SPI_LSB_FIRST_EN defined with 8'h01/8'h80. Required: the first mosi bit is 1 and the first miso bit is 0; data_out_master=8'h80, data_out_slave=8'h01.

Source files
------------

// File: rtl/spi_master_slave.sv
// SPI mode-0 loopback: master and slave engines exchange one byte full-duplex; SPI_LSB_FIRST_EN selects LSB-first.
// Latency: done rises 16*CLK_DIV cycles after the launch edge.
// Backpressure: none; a start rising edge while busy is dropped.
module spi_master_slave #(
   parameter int unsigned CLK_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data_in_master,
   input  logic [7:0] data_in_slave,
   output logic [7:0] data_out_master,
   output logic [7:0] data_out_slave,
   output logic       done,
   output logic       sclk,
   output logic       ss,
   output logic       mosi,
   output logic       miso
);

   typedef enum logic {IDLE, XFER} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state;
   logic       start_q;
   logic       start_rise;
   logic [7:0] m_shreg;
   logic [2:0] m_cnt;
   logic [7:0] div_cnt;
   logic [7:0] s_shreg;
   logic [2:0] s_cnt;
   logic       sclk_q;
   logic       s_rise;

   logic       m_first;
   logic       m_next;
   logic [7:0] m_shift;
   logic [7:0] s_shift;

`ifdef SPI_LSB_FIRST_EN
   assign m_first = data_in_master[0];
   assign m_next  = m_shreg[0];
   assign m_shift = {miso, m_shreg[7:1]};
   assign s_shift = {mosi, s_shreg[7:1]};
   assign miso    = s_shreg[0];
`else
   assign m_first = data_in_master[7];
   assign m_next  = m_shreg[7];
   assign m_shift = {m_shreg[6:0], miso};
   assign s_shift = {s_shreg[6:0], mosi};
   assign miso    = s_shreg[7];
`endif

   assign start_rise = start & ~start_q;
   assign s_rise     = sclk & ~sclk_q & ~ss;

   // Received bits share the transmit register: each rise shifts one in, each fall exposes the next tx bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         start_q         <= 1'b0;
         m_shreg         <= '0;
         m_cnt           <= '0;
         div_cnt         <= '0;
         sclk            <= 1'b0;
         ss              <= 1'b1;
         mosi            <= 1'b0;
         done            <= 1'b0;
         data_out_master <= '0;
      end else begin
         start_q <= start;
         case (state)
            IDLE: begin
               if (start_rise) begin
                  m_shreg <= data_in_master;
                  ss      <= 1'b0;
                  mosi    <= m_first;
                  done    <= 1'b0;
                  m_cnt   <= '0;
                  div_cnt <= '0;
                  state   <= XFER;
               end
            end
            XFER: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt <= '0;
                  if (!sclk) begin
                     sclk    <= 1'b1;
                     m_shreg <= m_shift;
                  end else begin
                     sclk <= 1'b0;
                     if (m_cnt == 3'd7) begin
                        ss              <= 1'b1;
                        mosi            <= 1'b0;
                        done            <= 1'b1;
                        data_out_master <= m_shreg;
                        state           <= IDLE;
                     end else begin
                        m_cnt <= m_cnt + 3'd1;
                        mosi  <= m_next;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Rise detection lags sclk by a cycle, so mosi is still the bit the master launched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_shreg        <= '0;
         s_cnt          <= '0;
         sclk_q         <= 1'b0;
         data_out_slave <= '0;
      end else begin
         sclk_q <= sclk;
         if (ss) begin
            s_shreg <= data_in_slave;
            s_cnt   <= '0;
         end else if (s_rise) begin
            s_shreg <= s_shift;
            if (s_cnt == 3'd7) begin
               data_out_slave <= s_shift;
               s_cnt          <= '0;
            end else begin
               s_cnt <= s_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_master_slave.sv
// Scoreboard bench: two instances (CLK_DIV=1 and CLK_DIV=4) driven with directed then random byte exchanges.
module tb_spi_master_slave;

`ifdef SPI_LSB_FIRST_EN
   localparam bit LSB = 1'b1;
`else
   localparam bit LSB = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      start;
   logic [1:0][7:0] dim, dis, dom, dos;
   logic [1:0]      done, sclk, ss, mosi, miso;

   always #5 clk = ~clk;

   spi_master_slave #(.CLK_DIV(1)) u_div1 (
      .clk(clk), .reset(rst_n), .start(start[0]),
      .data_in_master(dim[0]), .data_in_slave(dis[0]),
      .data_out_master(dom[0]), .data_out_slave(dos[0]),
      .done(done[0]), .sclk(sclk[0]), .ss(ss[0]), .mosi(mosi[0]), .miso(miso[0]));

   spi_master_slave #(.CLK_DIV(4)) u_div4 (
      .clk(clk), .reset(rst_n), .start(start[1]),
      .data_in_master(dim[1]), .data_in_slave(dis[1]),
      .data_out_master(dom[1]), .data_out_slave(dos[1]),
      .done(done[1]), .sclk(sclk[1]), .ss(ss[1]), .mosi(mosi[1]), .miso(miso[1]));

   typedef struct {
      int         u;
      logic [7:0] tx;
      logic [7:0] rx;
      int         launch;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int div_of(int u);
      return (u == 0) ? 1 : 4;
   endfunction

   // Bits in the order they travel on the wire, first-sent bit placed in [7].
   function automatic logic [7:0] wire_order(logic [7:0] b);
      logic [7:0] s;
      for (int i = 0; i < 8; i++) s[7-i] = LSB ? b[i] : b[7-i];
      return s;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: collects waveform facts per unit and pops the scoreboard on each done rise.
   logic [1:0] done_p, sclk_p, ss_p;
   int         ss_low[2], hi_run[2], lo_run[2], pulses[2], herr[2];
   logic [7:0] mseq[2], sseq[2];

   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (!rst_n) begin
            done_p[u] = 1'b0; sclk_p[u] = 1'b0; ss_p[u] = 1'b1;
            ss_low[u] = 0; hi_run[u] = 0; lo_run[u] = 0; pulses[u] = 0; herr[u] = 0;
            mseq[u] = '0; sseq[u] = '0;
         end else begin
            if (ss_p[u] && !ss[u]) begin
               tests++;
               if (q.size() == 0 || q[0].u != u) begin
                  fails++;
                  $display("FAIL spurious_launch unit=%0d actual=launch required=no_launch", u);
               end
               ss_low[u] = 0; hi_run[u] = 0; lo_run[u] = 0; pulses[u] = 0; herr[u] = 0;
               mseq[u] = '0; sseq[u] = '0;
            end
            if (sclk_p[u] && !sclk[u]) begin
               if (hi_run[u] != div_of(u)) herr[u]++;
               hi_run[u] = 0;
            end
            if (!ss[u]) begin
               ss_low[u]++;
               if (sclk[u]) begin
                  if (!sclk_p[u]) begin
                     pulses[u]++;
                     if (lo_run[u] != div_of(u)) herr[u]++;
                     lo_run[u] = 0;
                     mseq[u] = {mseq[u][6:0], mosi[u]};
                     sseq[u] = {sseq[u][6:0], miso[u]};
                  end
                  hi_run[u]++;
               end else begin
                  lo_run[u]++;
               end
            end
            if (done[u] && !done_p[u]) begin
               if (q.size() == 0 || q[0].u != u) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_done unit=%0d actual=1 required=0", u);
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk($sformatf("u%0d_data_out_master", u), 32'(dom[u]), 32'(e.rx));
                  chk($sformatf("u%0d_data_out_slave", u), 32'(dos[u]), 32'(e.tx));
                  chk($sformatf("u%0d_latency", u), 32'(cyc), 32'(e.launch + 16 * div_of(u)));
                  chk($sformatf("u%0d_sclk_pulses", u), 32'(pulses[u]), 32'd8);
                  chk($sformatf("u%0d_ss_low_cycles", u), 32'(ss_low[u]), 32'(16 * div_of(u)));
                  chk($sformatf("u%0d_half_period_errors", u), 32'(herr[u]), 32'd0);
                  chk($sformatf("u%0d_mosi_seq", u), 32'(mseq[u]), 32'(wire_order(e.tx)));
                  chk($sformatf("u%0d_miso_seq", u), 32'(sseq[u]), 32'(wire_order(e.rx)));
                  chk($sformatf("u%0d_idle_ss_sclk", u), {30'd0, ss[u], sclk[u]}, 32'h2);
               end
            end
            done_p[u] = done[u];
            sclk_p[u] = sclk[u];
            ss_p[u]   = ss[u];
         end
      end
   end

   task automatic launch(int u, logic [7:0] tx, logic [7:0] rx, int hold);
      exp_t e;
      @(negedge clk);
      dim[u]   = tx;
      dis[u]   = rx;
      start[u] = 1'b1;
      e.u = u; e.tx = tx; e.rx = rx; e.launch = cyc + 1;
      q.push_back(e);
      repeat (hold) @(negedge clk);
      start[u] = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 120) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL completion_timeout actual=pending%0d required=0", q.size());
         q.delete();
      end
   endtask

   task automatic chk_reset(int u);
      chk($sformatf("u%0d_rst_ss", u), 32'(ss[u]), 32'd1);
      chk($sformatf("u%0d_rst_sclk", u), 32'(sclk[u]), 32'd0);
      chk($sformatf("u%0d_rst_done", u), 32'(done[u]), 32'd0);
      chk($sformatf("u%0d_rst_dom", u), 32'(dom[u]), 32'd0);
      chk($sformatf("u%0d_rst_dos", u), 32'(dos[u]), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      start = '0;
      dim   = '0;
      dis   = '0;
      repeat (3) @(negedge clk);
      chk_reset(0);
      chk_reset(1);
      chk("u0_rst_mosi", 32'(mosi[0]), 32'd0);
      rst_n = 1'b1;

      // Basic exchange with start held for 16 cycles.
      launch(0, 8'hAA, 8'hCC, 16);
      wait_idle();

      // Start held well past done must not relaunch.
      launch(0, 8'h12, 8'h34, 30);
      wait_idle();
      repeat (3) @(negedge clk);
      chk("held_start_done", 32'(done[0]), 32'd1);
      chk("held_start_ss", 32'(ss[0]), 32'd1);

      launch(0, 8'h5A, 8'h3C, 1);
      chk("done_clears_at_launch", 32'(done[0]), 32'd0);
      wait_idle();

      // Reset in the middle of bit 4.
      launch(0, 8'h96, 8'h69, 1);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset(0);
      q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      launch(0, 8'hFF, 8'h00, 1);
      wait_idle();

      // Slow clock divider.
      launch(1, 8'h81, 8'h7E, 1);
      wait_idle();

      // Bit-order check pattern.
      launch(0, 8'h01, 8'h80, 1);
      wait_idle();
      launch(1, 8'h01, 8'h80, 1);
      wait_idle();

      // Back-to-back: second rise in the cycle after done.
      launch(0, 8'hC3, 8'h5A, 16);
      launch(0, 8'h3C, 8'hA5, 1);
      wait_idle();

      for (int i = 0; i < 14; i++) begin
         int u;
         u = int'($urandom_range(1, 0));
         launch(u, 8'($urandom), 8'($urandom), int'($urandom_range(20, 1)));
         wait_idle();
         repeat ($urandom_range(3, 0)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
